// File: rtl/mpadd_arbiter_if.sv
// mpadd_arbiter_if: client-side and adder-side signals of the shared multi-precision adder arbiter.
// slave modport is the arbiter's view; master modport is the environment's view (clients + adder).
// Client side: req/a_in/b_in in, grant/done/s_out/err/busy out. Adder side: add_a/add_b/add_write/add_start out, add_s/add_ready in.
interface mpadd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 256
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic [WIDTH:0] s_out;
  logic err;
  logic busy;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic add_write;
  logic add_start;
  logic [WIDTH:0] add_s;
  logic add_ready;
  modport slave (
    input req, a_in, b_in, add_s, add_ready,
    output grant, done, s_out, err, busy, add_a, add_b, add_write, add_start
  );
  modport master (
    output req, a_in, b_in, add_s, add_ready,
    input grant, done, s_out, err, busy, add_a, add_b, add_write, add_start
  );
endinterface

// File: rtl/mpadd_arbiter.sv
// mpadd_arbiter: round-robin scheduler sharing one WIDTH-bit multi-precision adder among NUM_REQ requesters.
// Ports: CLK clock, RST_N synchronous active-low reset, bus (slave modport of mpadd_arbiter_if)
// carrying the client request/result signals and the adder write/start/ready interface.
module mpadd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 256,
  parameter int TIMEOUT = 63
) (
  input logic CLK,
  input logic RST_N,
  mpadd_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_idx, w_sel;
  logic [NUM_REQ-1:0] r_grant;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] w_a [NUM_REQ];
  logic [WIDTH-1:0] w_b [NUM_REQ];
  logic [WIDTH:0] r_s;
  logic r_err;
  logic [CW-1:0] r_cnt;
  logic w_timeout, w_capture, w_finish;
  int w_best, w_dist;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_a[g] = bus.a_in[g*WIDTH +: WIDTH];
    assign w_b[g] = bus.b_in[g*WIDTH +: WIDTH];
  end
  // Winner is the requester at the smallest cyclic distance from the pointer.
  always_comb begin
    w_sel = '0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i >= int'(r_ptr)) ? i - int'(r_ptr) : i + NUM_REQ - int'(r_ptr);
      if (bus.req[i] && w_dist < w_best) begin
        w_best = w_dist;
        w_sel = IW'(i);
      end
    end
  end
  assign w_timeout = r_cnt == CW'(TIMEOUT);
  assign w_capture = r_state == IDLE && |bus.req;
  // add_ready takes priority over the timeout on the final WAIT cycle.
  assign w_finish = r_state == WAIT && (bus.add_ready || w_timeout);
  always_ff @(posedge CLK) r_state <= !RST_N ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_capture ? LOAD : IDLE;
      LOAD: w_next = START;
      START: w_next = WAIT;
      WAIT: w_next = w_finish ? DONE : WAIT;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_grant <= '0;
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_idx <= w_sel;
        r_grant <= NUM_REQ'(1) << w_sel;
        r_a <= w_a[w_sel];
        r_b <= w_b[w_sel];
      end
      if (r_state == START) r_cnt <= '0;
      else if (r_state == WAIT && !w_timeout) r_cnt <= r_cnt + 1'b1;
      if (w_finish) begin
        r_s <= bus.add_ready ? bus.add_s : '0;
        r_err <= !bus.add_ready;
      end
      // err only accompanies the done pulse; s_out is held until overwritten.
      if (r_state == DONE) begin
        r_ptr <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        r_grant <= '0;
        r_err <= 1'b0;
      end
    end
  end
  assign bus.grant = r_grant;
  assign bus.done = (r_state == DONE) ? r_grant : '0;
  assign bus.s_out = r_s;
  assign bus.err = r_err;
  assign bus.busy = r_state != IDLE;
  assign bus.add_a = r_a;
  assign bus.add_b = r_b;
  assign bus.add_write = r_state == LOAD;
  assign bus.add_start = r_state == START;
endmodule

// File: tb/tb_mpadd_arbiter.sv
// tb_mpadd_arbiter: randomized scoreboard bench for mpadd_arbiter with a latency-configurable adder stub.
module tb_mpadd_arbiter;
  localparam int N = 4;
  localparam int W = 256;
  localparam int TO = 63;
  typedef struct {
    int idx;
    logic [W:0] s;
    logic e;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mpadd_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();
  mpadd_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 8;
  int mptr = 0;
  int want[N];
  int served[N];
  logic [N-1:0] force_low = '0;
  logic [W-1:0] opa[N];
  logic [W-1:0] opb[N];
  logic [W:0] stub_sum = '0;
  int done_cyc = 0, write_cyc = 0, start_cyc = 0, idle_run = 0, t0 = 0;
  bit gap_chk = 0, seen_busy = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.a_in = {opa[3], opa[2], opa[1], opa[0]};
  assign bus.b_in = {opb[3], opb[2], opb[1], opb[0]};
  always_comb begin
    bus.req = '0;
    for (int i = 0; i < N; i++) bus.req[i] = (want[i] > served[i]) && !force_low[i];
  end
  task automatic chk(input string name, input logic [W+8:0] got, input logic [W+8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic logic [W-1:0] r256();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction
  // Adder stub: sum latched at write, ready pulsed lat clocks after start is seen (never if lat<0).
  initial begin
    bus.add_ready = 1'b0;
    bus.add_s = '0;
    forever begin
      @(negedge clk);
      if (bus.add_write) stub_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
      if (bus.add_start && lat >= 0) begin
        repeat (lat) @(posedge clk);
        #1;
        bus.add_s = stub_sum;
        bus.add_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.add_ready = 1'b0;
        bus.add_s = '0;
      end
    end
  end
  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (bus.add_write) write_cyc = cyc;
    if (bus.add_start) start_cyc = cyc;
    if (bus.done != '0) begin
      done_cyc = cyc;
      chk("done_onehot", 259'($onehot(bus.done)), 1);
      if (q.size() == 0) chk("done_unexpected", bus.done, 0);
      else begin
        mon_e = q.pop_front();
        chk("done_idx", bus.done, 1 << mon_e.idx);
        chk("grant_at_done", bus.grant, 1 << mon_e.idx);
        chk("s_out", bus.s_out, mon_e.s);
        chk("err", bus.err, mon_e.e);
      end
      for (int i = 0; i < N; i++) if (bus.done[i]) served[i]++;
    end else if (bus.err) chk("err_without_done", bus.err, 0);
    if (bus.busy) begin
      if (gap_chk && seen_busy && idle_run > 0) chk("busy_gap", idle_run, 1);
      seen_busy = 1;
      idle_run = 0;
    end else idle_run++;
  end
  // Reference: serve pending requesters in cyclic order from the pointer, one op each turn.
  task automatic fire(input logic [N-1:0] mask, input int rep, input bit to, input bit rnd);
    int c[N];
    int total = 0;
    int j;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      c[i] = mask[i] ? rep : 0;
      total += c[i];
      if (mask[i] && rnd) begin
        opa[i] = r256();
        opb[i] = r256();
      end
    end
    for (int n = 0; n < total; n++) begin
      j = mptr;
      while (c[j] == 0) j = (j + 1) % N;
      e.idx = j;
      e.s = to ? '0 : {1'b0, opa[j]} + {1'b0, opb[j]};
      e.e = to;
      q.push_back(e);
      c[j]--;
      mptr = (j + 1) % N;
    end
    for (int i = 0; i < N; i++) if (mask[i]) want[i] = served[i] + rep;
  endtask
  task automatic settle(input string name);
    int n = 0;
    while ((q.size() != 0 || bus.busy || bus.req != '0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completes"}, 259'(n < 3000), 1);
    q.delete();
  endtask
  task automatic chk_idle_outputs(input string p);
    chk({p, "_grant"}, bus.grant, 0);
    chk({p, "_done"}, bus.done, 0);
    chk({p, "_s_out"}, bus.s_out, 0);
    chk({p, "_err"}, bus.err, 0);
    chk({p, "_busy"}, bus.busy, 0);
    chk({p, "_add_write"}, bus.add_write, 0);
    chk({p, "_add_start"}, bus.add_start, 0);
    chk({p, "_add_a"}, bus.add_a, 0);
    chk({p, "_add_b"}, bus.add_b, 0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      want[i] = 0;
      served[i] = 0;
      opa[i] = '0;
      opb[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    // Serial adder, carry out of the top bit.
    lat = 8;
    opa[0] = '1;
    opb[0] = 256'd1;
    t0 = cyc;
    fire(4'b0001, 1, 0, 0);
    settle("serial");
    chk("serial_write_cyc", write_cyc - t0, 1);
    chk("serial_start_cyc", start_cyc - t0, 2);
    chk("serial_done_cyc", done_cyc - t0, 11);
    chk("serial_sum", bus.s_out, {1'b1, 256'b0});
    // Two simultaneous requesters.
    fire(4'b1010, 1, 0, 1);
    settle("pair");
    // All four held for two rounds; IDLE visited for exactly one cycle between ops.
    seen_busy = 0;
    gap_chk = 1;
    fire(4'b1111, 2, 0, 1);
    settle("rr8");
    gap_chk = 0;
    // Parallel adder latency.
    lat = 1;
    t0 = cyc;
    fire(4'b0100, 1, 0, 1);
    settle("parallel");
    chk("parallel_done_cyc", done_cyc - t0, 4);
    // Dead adder: timeout, then normal service.
    lat = -1;
    t0 = cyc;
    fire(4'b0010, 1, 1, 1);
    settle("timeout");
    chk("timeout_done_cyc", done_cyc - t0, TO + 4);
    lat = 8;
    fire(4'b0010, 1, 0, 1);
    settle("after_timeout");
    // Ready arriving long after the timeout must be ignored.
    lat = 70;
    fire(4'b1000, 1, 1, 1);
    settle("late_ready");
    repeat (30) @(negedge clk);
    // Reset while in WAIT with the pointer away from 0.
    lat = 8;
    fire(4'b0100, 1, 0, 1);
    settle("pre_reset");
    lat = -1;
    want[3] = served[3] + 1;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    rst_n = 1'b1;
    want[3] = served[3];
    mptr = 0;
    lat = 8;
    @(negedge clk);
    fire(4'b1100, 1, 0, 1);
    settle("post_reset");
    // Drop req and change operands after capture.
    fire(4'b0001, 1, 0, 1);
    @(negedge clk);
    chk("midop_grant", bus.grant, 1);
    @(negedge clk);
    force_low[0] = 1'b1;
    opa[0] = r256();
    opb[0] = r256();
    settle("midop");
    force_low = '0;
    // Random masks, repetitions and adder latencies.
    for (int t = 0; t < 12; t++) begin
      lat = $urandom_range(1, 20);
      fire(4'($urandom_range(1, 15)), $urandom_range(1, 2), 0, 1);
      settle("random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
